// File: rtl/axis_uart_tx_pkg.sv
// Shared types and helpers for the AXI-Stream UART transmitter.
// FSM state encodings and the clocks-per-bit calculation.
package axis_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic int calc_clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick on the last clk of each bit.
// Ports: clk, rst_n, clear (hold count at 0), bit_tick.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream byte sink serialising to a UART TX line (8N1, opt. parity).
// Ports: clk, rst_n, s_axis_{data,valid,last,ready}, tx, busy, msg_done.
module axis_uart_tx
  import axis_uart_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_axis_data,
  input  logic             s_axis_valid,
  input  logic             s_axis_last,
  output logic             s_axis_ready,
  output logic             tx,
  output logic             busy,
  output logic             msg_done
);

  localparam int CLKS_PER_BIT =
    calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int BCW =
    (WIDTH > 2) ? $clog2(WIDTH) : 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic             last_q;
  logic             par_q;
  logic             bit_tick;
  logic             hs;

  assign hs = s_axis_valid & s_axis_ready;

  // Timer idles at 0 so every frame's start bit
  // gets a full period; later states wrap on tick.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ST_IDLE),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      last_q       <= 1'b0;
      par_q        <= 1'b0;
      tx           <= 1'b1;
      s_axis_ready <= 1'b0;
      busy         <= 1'b0;
      msg_done     <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (hs) begin
            state        <= ST_START;
            tx           <= 1'b0;
            shreg        <= s_axis_data;
            last_q       <= s_axis_last;
            par_q        <= ^s_axis_data;
            bit_cnt      <= '0;
            s_axis_ready <= 1'b0;
            busy         <= 1'b1;
          end else begin
            s_axis_ready <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state <= ST_DATA;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt == BCW'(WIDTH - 1)) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                tx    <= par_q;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (bit_cnt == BCW'(STOP_BITS - 1)) begin
              state        <= ST_IDLE;
              bit_cnt      <= '0;
              busy         <= 1'b0;
              s_axis_ready <= 1'b1;
              msg_done     <= last_q;
              last_q       <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx: 8N1 and 8E2 instances.
// Scenario tasks check wire timing, handshake and msg_done.
module tb_axis_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] data0 = '0;
  logic       valid0 = 1'b0;
  logic       last0 = 1'b0;
  logic       ready0;
  logic       tx0;
  logic       busy0;
  logic       done0;

  logic [7:0] data1 = '0;
  logic       valid1 = 1'b0;
  logic       last1 = 1'b0;
  logic       ready1;
  logic       tx1;
  logic       busy1;
  logic       done1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_uart_tx #(
    .WIDTH(8), .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY_EN(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(data0), .s_axis_valid(valid0),
    .s_axis_last(last0), .s_axis_ready(ready0),
    .tx(tx0), .busy(busy0), .msg_done(done0)
  );

  axis_uart_tx #(
    .WIDTH(8), .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY_EN(1), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(data1), .s_axis_valid(valid1),
    .s_axis_last(last1), .s_axis_ready(ready1),
    .tx(tx1), .busy(busy1), .msg_done(done1)
  );

  // Independent line receiver for dut0 (10 clks/bit).
  int         cyc = 0;
  bit         mon_on = 0;
  int         mon_k = 0;
  int         mon_t = 0;
  logic [7:0] mon_sh = '0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         rx_stop[$];
  int         done_cnt = 0;
  int         done_cyc[$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (done0 === 1'b1) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      if (!rst_n) begin
        mon_on = 0;
      end else if (!mon_on) begin
        if (tx0 === 1'b0) begin
          mon_on = 1;
          mon_k  = 0;
          mon_t  = cyc;
        end
      end else begin
        mon_k++;
        if (mon_k >= 15 && mon_k <= 85 && mon_k % 10 == 5)
          mon_sh[(mon_k - 15) / 10] = tx0;
        if (mon_k == 95) begin
          rx_q.push_back(mon_sh);
          rx_t.push_back(mon_t);
          rx_stop.push_back(tx0 === 1'b1);
          mon_on = 0;
        end
      end
    end
  end

  task automatic clr_mon();
    rx_q.delete();
    rx_t.delete();
    rx_stop.delete();
    done_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic drain(input int n);
    int g;
    g = 0;
    while ((rx_q.size() < n || mon_on || busy0) && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (g >= 2000) begin
      n_err++;
      $display("FAIL drain_timeout got=%0d want=%0d frames",
               rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({tx0, ready0, busy0, done0} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_outs got=%b want=1000",
               {tx0, ready0, busy0, done0});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({tx0, ready0, busy0} !== 3'b110) begin
        n_err++;
        $display("FAIL idle_clk%0d got=%b want=110",
                 i, {tx0, ready0, busy0});
      end
    end
    n_cmp++;
    if (ready1 !== 1'b1 || tx1 !== 1'b1) begin
      n_err++;
      $display("FAIL idle_dut1 got=%b%b want=11", ready1, tx1);
    end
  endtask

  task automatic test_single();
    logic [9:0] wire_exp;
    int bad;
    int dn;
    wire_exp = 10'b1010010000;
    clr_mon();
    data0  = 8'h48;
    last0  = 1'b1;
    valid0 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    last0  = 1'b0;
    n_cmp++;
    if ({tx0, ready0, busy0} !== 3'b001) begin
      n_err++;
      $display("FAIL single_hs got=%b want=001",
               {tx0, ready0, busy0});
    end
    bad = 0;
    dn  = 0;
    for (int k = 1; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (tx0 !== wire_exp[k / 10]) bad++;
      if (done0 !== 1'b0) dn++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL single_wire got=%0d bad clks want=0", bad);
    end
    n_cmp++;
    if (dn != 0) begin
      n_err++;
      $display("FAIL single_early_done got=%0d want=0", dn);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done0, ready0, busy0, tx0} !== 4'b1101) begin
      n_err++;
      $display("FAIL single_end got=%b want=1101",
               {done0, ready0, busy0, tx0});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done0 !== 1'b0) begin
      n_err++;
      $display("FAIL single_pulse got=%b want=0", done0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[6];
    int idx;
    int g;
    bit h;
    msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
    clr_mon();
    idx    = 0;
    g      = 0;
    data0  = msg[0];
    last0  = 1'b0;
    valid0 = 1'b1;
    while (idx < 6 && g < 2000) begin
      h = ready0;
      @(posedge clk);
      #1;
      g++;
      if (h) begin
        idx++;
        if (idx < 6) begin
          data0 = msg[idx];
          last0 = (idx == 5);
        end else begin
          valid0 = 1'b0;
          last0  = 1'b0;
        end
      end
    end
    valid0 = 1'b0;
    drain(6);
    n_cmp++;
    if (rx_q.size() != 6) begin
      n_err++;
      $display("FAIL b2b_count got=%0d want=6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (rx_q[i] !== msg[i] || !rx_stop[i]) begin
          n_err++;
          $display("FAIL b2b_byte%0d got=%h stop=%0d want=%h",
                   i, rx_q[i], rx_stop[i], msg[i]);
        end
      end
      for (int i = 1; i < 6; i++) begin
        n_cmp++;
        if (rx_t[i] - rx_t[i-1] != 101) begin
          n_err++;
          $display("FAIL b2b_gap%0d got=%0d want=101",
                   i, rx_t[i] - rx_t[i-1]);
        end
      end
      n_cmp++;
      if (done_cnt != 1 || done_cyc[0] != rx_t[5] + 100) begin
        n_err++;
        $display("FAIL b2b_done got=%0d pulses want=1 at %0d",
                 done_cnt, rx_t[5] + 100);
      end
    end
  endtask

  task automatic test_busy_toggle();
    logic [7:0] exp_q[$];
    int g;
    int k;
    bit h;
    clr_mon();
    g      = 0;
    k      = 0;
    last0  = 1'b0;
    valid0 = 1'b1;
    data0  = 8'h3A;
    while (exp_q.size() < 3 && g < 2000) begin
      h = ready0;
      if (h) exp_q.push_back(data0);
      @(posedge clk);
      #1;
      g++;
      k++;
      data0 = 8'((k * 37 + 3) & 255);
      if (exp_q.size() == 3) valid0 = 1'b0;
    end
    valid0 = 1'b0;
    drain(3);
    n_cmp++;
    if (rx_q.size() != 3) begin
      n_err++;
      $display("FAIL toggle_count got=%0d want=3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL toggle_byte%0d got=%h want=%h",
                   i, rx_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (done_cnt != 0) begin
      n_err++;
      $display("FAIL toggle_done got=%0d want=0", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clr_mon();
    data0  = 8'hA5;
    last0  = 1'b1;
    valid0 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    last0  = 1'b0;
    repeat (44) @(posedge clk);
    #1;
    n_cmp++;
    if (tx0 !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_pre got=%b want=0", tx0);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx0, busy0, ready0, done0} !== 4'b1000) begin
      n_err++;
      $display("FAIL rstmid_async got=%b want=1000",
               {tx0, busy0, ready0, done0});
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != 0 || rx_q.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_discard got=%0d done %0d frames want=0 0",
               done_cnt, rx_q.size());
    end
    data0  = 8'h3C;
    last0  = 1'b1;
    valid0 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    last0  = 1'b0;
    drain(1);
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      n_err++;
      $display("FAIL rstmid_next got=%0d frames want=1 of 3c",
               rx_q.size());
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL rstmid_done got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_parity_2stop();
    logic [11:0] wire_exp;
    int bad;
    wire_exp = 12'b111000001110;
    data1  = 8'h07;
    last1  = 1'b1;
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    last1  = 1'b0;
    bad = (tx1 !== 1'b0) ? 1 : 0;
    for (int k = 1; k < 120; k++) begin
      @(posedge clk);
      #1;
      if (tx1 !== wire_exp[k / 10]) bad++;
      if (done1 !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL par_wire got=%0d bad clks want=0", bad);
    end
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL par_busy119 got=%b want=1", busy1);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done1, ready1, busy1, tx1} !== 4'b1101) begin
      n_err++;
      $display("FAIL par_end got=%b want=1101",
               {done1, ready1, busy1, tx1});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_toggle();
    test_reset_mid();
    test_parity_2stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
